// File: rtl/sub_writeback_stage.sv
// sub_writeback_stage: subtractor result FIFO with Z/N/C flags and an architectural flags register.
// Optional feature macro: SUB_WB_SATURATE_EN (a borrow forces the stored result to 8'h00).
`default_nettype none

module sub_writeback_stage #(
  parameter int DEPTH = 2,
  parameter int TAGW  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [7:0]               dIn,
  input  logic                     bIn,
  input  logic [TAGW-1:0]          tagIn,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [7:0]               dOut,
  output logic [TAGW-1:0]          tagOut,
  output logic [2:0]               flagsOut,
  output logic [2:0]               archFlags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);

  logic [7:0]      data_mem [DEPTH];
  logic [TAGW-1:0] tag_mem  [DEPTH];
  logic [2:0]      flag_mem [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [7:0]      wdata;
  logic [2:0]      wflags;

  always_comb begin
`ifdef SUB_WB_SATURATE_EN
    wdata = bIn ? 8'h00 : dIn;
`else
    wdata = dIn;
`endif
    // flags follow the value actually stored, so saturation yields {C=1,N=0,Z=1}
    wflags = {bIn, wdata[7], (wdata == 8'h00)};
  end

  assign inReady  = (count != FULL_CNT);
  assign outValid = (count != '0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  assign dOut     = data_mem[rd_ptr];
  assign tagOut   = tag_mem[rd_ptr];
  assign flagsOut = flag_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
        flag_mem[i] <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= wdata;
      tag_mem[wr_ptr]  <= tagIn;
      flag_mem[wr_ptr] <= wflags;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      archFlags <= 3'b000;
    end else if (pop) begin
      archFlags <= flag_mem[rd_ptr];
    end
  end

endmodule

`default_nettype wire
